// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer_if
//  Description : Bundles the PC register, instruction memory, decode and
//                redirect signals seen by the fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if #(
    parameter int SIZE = 32
);
    // PC register side
    logic [SIZE-1:0] pc;
    logic [SIZE-1:0] pc_next;
    logic            pc_load;
    // Instruction memory side
    logic [SIZE-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [31:0]     imem_data;
    // Decode side
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    // Branch/jump redirect
    logic            redirect;
    logic [SIZE-1:0] redirect_addr;

    // Sequencer view
    modport master (
        input  pc, imem_ack, imem_data, instr_ready, redirect, redirect_addr,
        output pc_next, pc_load, imem_addr, imem_req, instr, instr_valid
    );

    // Environment view (PC register, memory, decode)
    modport slave (
        output pc, imem_ack, imem_data, instr_ready, redirect, redirect_addr,
        input  pc_next, pc_load, imem_addr, imem_req, instr, instr_valid
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer
//  Description : Fetches the word at the current PC, hands it to decode with
//                a valid/ready handshake and produces the next PC (PC+4 or a
//                redirect target) with a one-cycle load strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter int              SIZE       = 32,
    parameter logic [SIZE-1:0] RESET_ADDR = '0
) (
    input  wire logic               ctrl,
    input  wire logic               reset,
    pc_fetch_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] c_align_mask = ~SIZE'(3);
    localparam logic [SIZE-1:0] c_pc_step    = SIZE'(4);

    state_t          r_state;
    logic [SIZE-1:0] r_pc_next;
    logic            r_pc_load;
    logic            r_imem_req;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic            r_discard;
    logic [SIZE-1:0] r_target;

    state_t          w_state_nxt;
    logic [SIZE-1:0] w_pc_next_nxt;
    logic            w_pc_load_nxt;
    logic            w_imem_req_nxt;
    logic [31:0]     w_instr_nxt;
    logic            w_instr_valid_nxt;
    logic            w_discard_nxt;
    logic [SIZE-1:0] w_target_nxt;

    logic [SIZE-1:0] w_pc_aligned;
    logic [SIZE-1:0] w_redir_aligned;

    // Word-aligned views of the current PC and the redirect target
    assign w_pc_aligned    = bus.pc & c_align_mask;
    assign w_redir_aligned = bus.redirect_addr & c_align_mask;

    assign bus.imem_addr   = w_pc_aligned;
    assign bus.pc_next     = r_pc_next;
    assign bus.pc_load     = r_pc_load;
    assign bus.imem_req    = r_imem_req;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;

    // Next-state and next-output decode for the fetch FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_next_nxt     = r_pc_next;
        w_pc_load_nxt     = 1'b0;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_discard_nxt     = r_discard;
        w_target_nxt      = r_target;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (bus.redirect) begin
                    w_pc_next_nxt = w_redir_aligned;
                    w_pc_load_nxt = 1'b1;
                end
            end

            S_REQ: begin
                if (!r_imem_req) begin
                    // PC is being loaded this cycle; no request is in flight
                    if (bus.redirect) begin
                        w_pc_next_nxt = w_redir_aligned;
                        w_pc_load_nxt = 1'b1;
                    end
                end else if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        w_pc_next_nxt = w_redir_aligned;
                        w_pc_load_nxt = 1'b1;
                        w_discard_nxt = 1'b0;
                    end else if (r_discard) begin
                        w_pc_next_nxt = r_target;
                        w_pc_load_nxt = 1'b1;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_instr_nxt       = bus.imem_data;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_next_nxt     = w_pc_aligned + c_pc_step;
                        w_pc_load_nxt     = 1'b1;
                        w_state_nxt       = S_HOLD;
                    end
                end else if (bus.redirect) begin
                    // Request cannot be aborted: remember to drop its data
                    w_discard_nxt = 1'b1;
                    w_target_nxt  = w_redir_aligned;
                end
            end

            S_HOLD: begin
                if (bus.redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_next_nxt     = w_redir_aligned;
                    w_pc_load_nxt     = 1'b1;
                    w_state_nxt       = S_REQ;
                end else if (r_instr_valid && bus.instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Request only once the PC register holds the address to fetch
        w_imem_req_nxt = (w_state_nxt == S_REQ) && !w_pc_load_nxt;
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge ctrl) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc_next     <= RESET_ADDR;
            r_pc_load     <= 1'b0;
            r_imem_req    <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
            r_target      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_next     <= w_pc_next_nxt;
            r_pc_load     <= w_pc_load_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_discard     <= w_discard_nxt;
            r_target      <= w_target_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_sequencer
//  Description : Scoreboard bench for pc_fetch_sequencer. Directed stimulus
//                pushes expected fetch addresses, PC loads and delivered
//                instructions; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic ctrl  = 1'b0;
    logic reset = 1'b0;

    always #5 ctrl = ~ctrl;

    pc_fetch_sequencer_if #(.SIZE(32)) bus ();

    pc_fetch_sequencer #(
        .SIZE       (32),
        .RESET_ADDR (32'h0000_0080)
    ) dut (
        .ctrl  (ctrl),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] q_addr[$];
    logic [31:0] q_load[$];
    logic [31:0] q_instr[$];
    int errors = 0;
    int checks = 0;

    // PC register: resets to 0, takes pc_next on the load strobe
    always @(posedge ctrl) begin
        if (!reset)            bus.pc <= 32'h0;
        else if (bus.pc_load)  bus.pc <= bus.pc_next;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected (got 1, expected 0)", nm);
    endtask

    // Monitor: compare every memory completion, PC load and accepted instr
    always @(negedge ctrl) begin
        if (bus.imem_req && bus.imem_ack) begin
            if (q_addr.size() == 0) unexpected("imem_addr");
            else chk("imem_addr", bus.imem_addr, q_addr.pop_front());
        end
        if (bus.pc_load) begin
            if (q_load.size() == 0) unexpected("pc_next");
            else chk("pc_next", bus.pc_next, q_load.pop_front());
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            if (q_instr.size() == 0) unexpected("instr");
            else chk("instr", bus.instr, q_instr.pop_front());
        end
    end

    task automatic tick();
        @(posedge ctrl);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 50) begin
            tick();
            n++;
        end
        chk1("wait_req", bus.imem_req, 1'b1);
    endtask

    task automatic mem_ack(input logic [31:0] data, input int wait_cycles);
        wait_req();
        repeat (wait_cycles) tick();
        bus.imem_ack  = 1'b1;
        bus.imem_data = data;
        tick();
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_imem_req"},    bus.imem_req,    1'b0);
        chk1({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        chk1({tag, "_pc_load"},     bus.pc_load,     1'b0);
        chk ({tag, "_instr"},       bus.instr,       32'h0);
        chk ({tag, "_pc_next"},     bus.pc_next,     32'h0000_0080);
    endtask

    initial begin
        bus.imem_ack      = 1'b0;
        bus.imem_data     = 32'h0;
        bus.instr_ready   = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;

        // Reset for three cycles
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b1;

        // First fetch at 0, decode ready
        q_addr.push_back(32'h0);
        q_load.push_back(32'h4);
        q_instr.push_back(32'h2008_0005);
        mem_ack(32'h2008_0005, 1);
        chk1("first_valid", bus.instr_valid, 1'b1);
        tick();
        chk1("second_req", bus.imem_req, 1'b1);
        chk("second_addr", bus.imem_addr, 32'h4);

        // Back-pressure: decode stalls four cycles
        bus.instr_ready = 1'b0;
        q_addr.push_back(32'h4);
        q_load.push_back(32'h8);
        q_instr.push_back(32'h1111_1111);
        mem_ack(32'h1111_1111, 1);
        chk1("bp_load_first", bus.pc_load, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("bp_valid", bus.instr_valid, 1'b1);
            chk ("bp_instr", bus.instr, 32'h1111_1111);
            chk1("bp_req",   bus.imem_req, 1'b0);
            chk1("bp_load",  bus.pc_load, 1'b0);
        end
        bus.instr_ready = 1'b1;
        tick();

        // Redirect in HOLD to 0x100 while decode is ready: instruction dropped
        q_addr.push_back(32'h8);
        q_load.push_back(32'hC);
        mem_ack(32'hAAAA_AAAA, 0);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h100;
        q_load.push_back(32'h100);
        tick();
        bus.redirect = 1'b0;
        chk1("hold_redir_valid", bus.instr_valid, 1'b0);
        chk1("hold_redir_req",   bus.imem_req, 1'b0);
        wait_req();
        chk("hold_redir_addr", bus.imem_addr, 32'h100);

        // Normal fetch at the redirect target
        q_addr.push_back(32'h100);
        q_load.push_back(32'h104);
        q_instr.push_back(32'h2222_2222);
        mem_ack(32'h2222_2222, 0);
        tick();

        // Redirect while REQ waits (0x200 then 0x40, last wins), ack 3 cycles later
        wait_req();
        q_addr.push_back(32'h104);
        q_load.push_back(32'h40);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h200;
        tick();
        bus.redirect_addr = 32'h40;
        tick();
        bus.redirect = 1'b0;
        tick();
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack  = 1'b0;
        chk1("discard_valid", bus.instr_valid, 1'b0);
        chk1("discard_req",   bus.imem_req, 1'b0);
        tick();
        chk1("refetch_req",  bus.imem_req, 1'b1);
        chk ("refetch_addr", bus.imem_addr, 32'h40);

        // Redirect coincident with ack; target low bits ignored
        q_addr.push_back(32'h40);
        q_load.push_back(32'hFFFF_FFFC);
        tick();
        bus.imem_ack      = 1'b1;
        bus.imem_data     = 32'h7777_7777;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'hFFFF_FFFF;
        tick();
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        chk1("same_cyc_valid", bus.instr_valid, 1'b0);

        // Fetch at the top of memory: PC+4 wraps to 0
        q_addr.push_back(32'hFFFF_FFFC);
        q_load.push_back(32'h0);
        mem_ack(32'h4444_4444, 1);
        chk("wrap_instr", bus.instr, 32'h4444_4444);
        // Redirect in HOLD to an unaligned target
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h103;
        q_load.push_back(32'h100);
        tick();
        bus.redirect = 1'b0;

        // Reset in the middle of REQ, ack arrives during reset
        wait_req();
        reset = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h5555_5555;
        tick();
        bus.imem_ack = 1'b0;
        chk_reset_outputs("ackrst");
        reset = 1'b1;

        // Fetch restarts from 0
        q_addr.push_back(32'h0);
        q_load.push_back(32'h4);
        q_instr.push_back(32'h6666_6666);
        mem_ack(32'h6666_6666, 1);
        repeat (3) tick();

        chk("q_addr_left",  32'(q_addr.size()),  32'h0);
        chk("q_load_left",  32'(q_load.size()),  32'h0);
        chk("q_instr_left", 32'(q_instr.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
